// File: rtl/pipe_pkg.sv
// Shared types and constants for the 3-stage pipeline control slice.
//   state_e    : sequencer states
//   MXRB_*     : write-back source select encodings
//   REG_IDX_W  : register-index width
package pipe_pkg;

  localparam int unsigned REG_IDX_W = 4;

  localparam logic [1:0] MXRB_ALU = 2'b00;
  localparam logic [1:0] MXRB_MEM = 2'b01;
  localparam logic [1:0] MXRB_PC  = 2'b10;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StLoad,
    StRun,
    StStall,
    StFlush,
    StDrain
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
//   id_ra_i/id_rb_i, id_use_ra_i/id_use_rb_i : sources read by the IF/ID instruction
//   ex_wc_i, ex_w_rb_i, ex_s_mxrb_i          : destination / write-back info of EX/MEM
//   hazard_o                                 : IF/ID needs a value EX/MEM is still loading
module hazard_detect #(
  parameter logic [1:0] MemSel = pipe_pkg::MXRB_MEM
) (
  input  logic [pipe_pkg::REG_IDX_W-1:0] id_ra_i,
  input  logic [pipe_pkg::REG_IDX_W-1:0] id_rb_i,
  input  logic                           id_use_ra_i,
  input  logic                           id_use_rb_i,
  input  logic [pipe_pkg::REG_IDX_W-1:0] ex_wc_i,
  input  logic                           ex_w_rb_i,
  input  logic [1:0]                     ex_s_mxrb_i,
  output logic                           hazard_o
);

  logic ra_match, rb_match;

  assign ra_match = id_use_ra_i && (id_ra_i == ex_wc_i);
  assign rb_match = id_use_rb_i && (id_rb_i == ex_wc_i);
  // Only a memory load is late; ALU/PC results are ready for the next stage.
  assign hazard_o = ex_w_rb_i && (ex_s_mxrb_i == MemSel) && (ra_match || rb_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the IF/ID -> EX/MEM -> WB pipeline.
//   CLK, RESET (sync, active-high)
//   start, load_req, halt_req                   : run control
//   id_* / ex_* , branch_taken                  : hazard and branch inputs
//   pc_*, reg_ifid_exmem_*, reg_exmem_wb_*      : reset/enable pins of PC and stage registers
//   im_load_en, running                         : status
//   stall_cnt, flush_cnt                        : saturating performance counters
module pipeline_ctrl #(
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16,
  parameter logic [1:0]  MXRB_MEM     = pipe_pkg::MXRB_MEM
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           start,
  input  logic                           load_req,
  input  logic                           halt_req,
  input  logic [pipe_pkg::REG_IDX_W-1:0] id_RA,
  input  logic [pipe_pkg::REG_IDX_W-1:0] id_RB,
  input  logic                           id_use_RA,
  input  logic                           id_use_RB,
  input  logic [pipe_pkg::REG_IDX_W-1:0] ex_WC,
  input  logic                           ex_W_RB,
  input  logic [1:0]                     ex_S_MXRB,
  input  logic                           branch_taken,
  output logic                           pc_RESET,
  output logic                           pc_ENABLE,
  output logic                           reg_ifid_exmem_RESET,
  output logic                           reg_ifid_exmem_ENABLE,
  output logic                           reg_exmem_wb_RESET,
  output logic                           reg_exmem_wb_ENABLE,
  output logic                           im_load_en,
  output logic                           running,
  output logic [CNT_W-1:0]               stall_cnt,
  output logic [CNT_W-1:0]               flush_cnt
);

  import pipe_pkg::*;

  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned FlW  = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [RstW-1:0] RstInit = RstW'(RST_CYCLES - 1);
  localparam logic [FlW-1:0]  FlInit  = FlW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  state_e           state_q, state_d;
  logic [RstW-1:0]  rst_ctr_q, rst_ctr_d;
  logic [FlW-1:0]   fl_ctr_q, fl_ctr_d;
  logic [1:0]       drn_ctr_q, drn_ctr_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic             hazard;

  hazard_detect #(
    .MemSel(MXRB_MEM)
  ) u_hazard_detect (
    .id_ra_i    (id_RA),
    .id_rb_i    (id_RB),
    .id_use_ra_i(id_use_RA),
    .id_use_rb_i(id_use_RB),
    .ex_wc_i    (ex_WC),
    .ex_w_rb_i  (ex_W_RB),
    .ex_s_mxrb_i(ex_S_MXRB),
    .hazard_o   (hazard)
  );

  always_comb begin
    state_d               = state_q;
    rst_ctr_d             = rst_ctr_q;
    fl_ctr_d              = fl_ctr_q;
    drn_ctr_d             = drn_ctr_q;
    stall_inc             = 1'b0;
    flush_inc             = 1'b0;
    pc_RESET              = 1'b0;
    pc_ENABLE             = 1'b0;
    reg_ifid_exmem_RESET  = 1'b0;
    reg_ifid_exmem_ENABLE = 1'b0;
    reg_exmem_wb_RESET    = 1'b0;
    reg_exmem_wb_ENABLE   = 1'b0;
    im_load_en            = 1'b0;
    running               = 1'b0;

    unique case (state_q)
      StInit: begin
        pc_RESET           = 1'b1;
        reg_ifid_exmem_RESET = 1'b1;
        reg_exmem_wb_RESET = 1'b1;
        if (rst_ctr_q == '0) state_d = StIdle;
        else                 rst_ctr_d = rst_ctr_q - 1'b1;
      end
      StIdle: begin
        if (load_req)   state_d = StLoad;
        else if (start) state_d = StRun;
      end
      StLoad: begin
        im_load_en           = 1'b1;
        pc_RESET             = 1'b1;
        reg_ifid_exmem_RESET = 1'b1;
        reg_exmem_wb_RESET   = 1'b1;
        // Re-run the reset sequence so the next program starts from a clean PC.
        if (!load_req) begin
          state_d   = StInit;
          rst_ctr_d = RstInit;
        end
      end
      StRun: begin
        running               = 1'b1;
        pc_ENABLE             = 1'b1;
        reg_ifid_exmem_ENABLE = 1'b1;
        reg_exmem_wb_ENABLE   = 1'b1;
        if (branch_taken) begin
          // Squash the wrong-path instruction while the target loads into the PC.
          reg_ifid_exmem_RESET = 1'b1;
          flush_inc            = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d  = StFlush;
            fl_ctr_d = FlInit;
          end
        end else if (hazard) begin
          pc_ENABLE            = 1'b0;
          reg_ifid_exmem_RESET = 1'b1;
          stall_inc            = 1'b1;
          state_d              = StStall;
        end else if (halt_req) begin
          state_d   = StDrain;
          drn_ctr_d = 2'd2;
        end
      end
      StStall: begin
        // Producer has moved on to WB, so the held consumer can proceed.
        running               = 1'b1;
        pc_ENABLE             = 1'b1;
        reg_ifid_exmem_ENABLE = 1'b1;
        reg_exmem_wb_ENABLE   = 1'b1;
        state_d               = StRun;
      end
      StFlush: begin
        running               = 1'b1;
        pc_ENABLE             = 1'b1;
        reg_ifid_exmem_ENABLE = 1'b1;
        reg_ifid_exmem_RESET  = 1'b1;
        reg_exmem_wb_ENABLE   = 1'b1;
        flush_inc             = 1'b1;
        if (fl_ctr_q == '0) state_d = StRun;
        else                fl_ctr_d = fl_ctr_q - 1'b1;
      end
      StDrain: begin
        reg_ifid_exmem_ENABLE = 1'b1;
        reg_ifid_exmem_RESET  = 1'b1;
        reg_exmem_wb_ENABLE   = 1'b1;
        if (drn_ctr_q == 2'd1) begin
          state_d   = StInit;
          rst_ctr_d = RstInit;
        end else begin
          drn_ctr_d = drn_ctr_q - 1'b1;
        end
      end
      default: begin
        state_d   = StInit;
        rst_ctr_d = RstInit;
      end
    endcase

    // RESET takes effect on the pins in the same cycle, whatever the state.
    if (RESET) begin
      pc_RESET              = 1'b1;
      pc_ENABLE             = 1'b0;
      reg_ifid_exmem_RESET  = 1'b1;
      reg_ifid_exmem_ENABLE = 1'b0;
      reg_exmem_wb_RESET    = 1'b1;
      reg_exmem_wb_ENABLE   = 1'b0;
      im_load_en            = 1'b0;
      running               = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StInit;
      rst_ctr_q   <= RstInit;
      fl_ctr_q    <= '0;
      drn_ctr_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rst_ctr_q <= rst_ctr_d;
      fl_ctr_q  <= fl_ctr_d;
      drn_ctr_q <= drn_ctr_d;
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a default instance (FLUSH_CYCLES=2) and a CNT_W=2 instance
// share all inputs. Each row of stimulus pushes its expected outputs to a scoreboard queue;
// the row's test task pops and compares once outputs settle mid-cycle.
module tb_pipeline_ctrl;

  localparam logic [7:0] C_INIT = 8'hA8;  // {pcR,pcE,ifR,ifE,wbR,wbE,im,run}
  localparam logic [7:0] C_IDLE = 8'h00;
  localparam logic [7:0] C_LOAD = 8'hAA;
  localparam logic [7:0] C_RUN  = 8'h55;
  localparam logic [7:0] C_HAZ  = 8'h35;
  localparam logic [7:0] C_BR   = 8'h75;
  localparam logic [7:0] C_DRN  = 8'h34;

  typedef struct packed {
    logic       rst, st, ld, hl;
    logic [1:0] hz;  // 0 no write, 1 RA load-use, 2 RA from ALU, 3 RB load-use
    logic       br;
    logic [7:0] ctrl;
    logic       si, fi;
  } row_t;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [15:0] sc, fc;
    logic [1:0]  ssc, sfc;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET, start, load_req, halt_req, branch_taken;
  logic [3:0] id_RA, id_RB, ex_WC;
  logic id_use_RA, id_use_RB, ex_W_RB;
  logic [1:0] ex_S_MXRB;

  logic pc_RESET, pc_ENABLE, ie_RESET, ie_ENABLE, ew_RESET, ew_ENABLE, im_load_en, running;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_pc_RESET, s_pc_ENABLE, s_ie_RESET, s_ie_ENABLE, s_ew_RESET, s_ew_ENABLE;
  logic s_im_load_en, s_running;
  logic [1:0] s_stall_cnt, s_flush_cnt;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.RST_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(16), .MXRB_MEM(2'b01)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .load_req(load_req), .halt_req(halt_req),
    .id_RA(id_RA), .id_RB(id_RB), .id_use_RA(id_use_RA), .id_use_RB(id_use_RB),
    .ex_WC(ex_WC), .ex_W_RB(ex_W_RB), .ex_S_MXRB(ex_S_MXRB), .branch_taken(branch_taken),
    .pc_RESET(pc_RESET), .pc_ENABLE(pc_ENABLE),
    .reg_ifid_exmem_RESET(ie_RESET), .reg_ifid_exmem_ENABLE(ie_ENABLE),
    .reg_exmem_wb_RESET(ew_RESET), .reg_exmem_wb_ENABLE(ew_ENABLE),
    .im_load_en(im_load_en), .running(running), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.RST_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(2), .MXRB_MEM(2'b01)) dut_sat (
    .CLK(CLK), .RESET(RESET), .start(start), .load_req(load_req), .halt_req(halt_req),
    .id_RA(id_RA), .id_RB(id_RB), .id_use_RA(id_use_RA), .id_use_RB(id_use_RB),
    .ex_WC(ex_WC), .ex_W_RB(ex_W_RB), .ex_S_MXRB(ex_S_MXRB), .branch_taken(branch_taken),
    .pc_RESET(s_pc_RESET), .pc_ENABLE(s_pc_ENABLE),
    .reg_ifid_exmem_RESET(s_ie_RESET), .reg_ifid_exmem_ENABLE(s_ie_ENABLE),
    .reg_exmem_wb_RESET(s_ew_RESET), .reg_exmem_wb_ENABLE(s_ew_ENABLE),
    .im_load_en(s_im_load_en), .running(s_running),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  function automatic row_t mk(input logic rst, input logic st, input logic ld, input logic hl,
                              input logic [1:0] hz, input logic br, input logic [7:0] ctrl,
                              input logic si, input logic fi);
    row_t r;
    r.rst = rst; r.st = st; r.ld = ld; r.hl = hl; r.hz = hz; r.br = br;
    r.ctrl = ctrl; r.si = si; r.fi = fi;
    return r;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Drive one cycle of inputs and push what the outputs must be during that cycle.
  task automatic drive_row(input row_t r);
    exp_t e;
    RESET = r.rst; start = r.st; load_req = r.ld; halt_req = r.hl; branch_taken = r.br;
    ex_WC = 4'd5; ex_W_RB = (r.hz != 2'd0); ex_S_MXRB = (r.hz == 2'd2) ? 2'b00 : 2'b01;
    id_RA = 4'd5; id_RB = 4'd3; id_use_RA = 1'b1; id_use_RB = 1'b1;
    if (r.hz == 2'd3) begin
      id_use_RA = 1'b0;
      id_RB     = 4'd5;
    end
    e.ctrl = r.ctrl;
    e.sc   = 16'(m_stall);
    e.fc   = 16'(m_flush);
    e.ssc  = 2'(sat3(m_stall));
    e.sfc  = 2'(sat3(m_flush));
    sb.push_back(e);
    if (r.rst) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_stall += int'(r.si);
      m_flush += int'(r.fi);
    end
  endtask

  function automatic exp_t observe();
    exp_t g;
    g.ctrl = {pc_RESET, pc_ENABLE, ie_RESET, ie_ENABLE, ew_RESET, ew_ENABLE, im_load_en, running};
    g.sc = stall_cnt; g.fc = flush_cnt; g.ssc = s_stall_cnt; g.sfc = s_flush_cnt;
    return g;
  endfunction

  task automatic test_reset();
    row_t rows[$];
    exp_t got, e;
    for (int k = 0; k < 3; k++) rows.push_back(mk(1, 0, 0, 0, 0, 0, C_INIT, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_INIT, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_INIT, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_IDLE, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_IDLE, 0, 0));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge CLK);
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_load();
    row_t rows[$];
    exp_t got, e;
    rows.push_back(mk(0, 1, 1, 0, 0, 0, C_IDLE, 0, 0));  // load_req beats start
    rows.push_back(mk(0, 0, 1, 0, 0, 0, C_LOAD, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_LOAD, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_INIT, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_INIT, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_IDLE, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, C_IDLE, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge CLK);
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL load[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    exp_t got, e;
    rows.push_back(mk(0, 0, 0, 0, 2, 0, C_RUN, 0, 0));  // ALU producer: no stall
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_RUN, 0, 0));  // no register write: no stall
    rows.push_back(mk(0, 0, 0, 0, 1, 0, C_HAZ, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 1, 0, C_RUN, 0, 0));  // STALL: not re-evaluated
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 3, 0, C_HAZ, 1, 0));  // hazard through RB
    rows.push_back(mk(0, 0, 0, 0, 3, 0, C_RUN, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge CLK);
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL stall[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    exp_t got, e;
    rows.push_back(mk(0, 0, 0, 0, 1, 1, C_BR, 0, 1));   // branch beats hazard
    rows.push_back(mk(0, 0, 0, 1, 0, 0, C_BR, 0, 1));   // FLUSH ignores halt
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge CLK);
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL branch[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_halt();
    row_t rows[$];
    exp_t got, e;
    rows.push_back(mk(0, 0, 0, 1, 1, 0, C_HAZ, 1, 0));  // hazard beats halt
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 0, C_RUN, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_DRN, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_DRN, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_INIT, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_INIT, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_IDLE, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, C_IDLE, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge CLK);
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL halt[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_mid_reset_sat();
    row_t rows[$];
    exp_t got, e;
    rows.push_back(mk(0, 0, 0, 0, 1, 0, C_HAZ, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 1, 0, C_HAZ, 1, 0));
    rows.push_back(mk(1, 0, 0, 0, 1, 0, C_INIT, 0, 0));  // RESET during STALL
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_INIT, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_INIT, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, C_IDLE, 0, 0));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge CLK);
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL mid_reset_sat[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; load_req = 1'b0; halt_req = 1'b0; branch_taken = 1'b0;
    id_RA = '0; id_RB = '0; ex_WC = '0; id_use_RA = 1'b0; id_use_RB = 1'b0;
    ex_W_RB = 1'b0; ex_S_MXRB = 2'b00;
    @(posedge CLK); #1;
    test_reset();
    test_load();
    test_stall();
    test_branch();
    test_halt();
    test_mid_reset_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencer for the 3-stage processor pipeline (IF/ID, EX/MEM, WB). It drives the RESET/ENABLE pins of the PC and of both pipeline registers. It runs a power-up reset sequence, gates program loading, detects load-use hazards (stall plus bubble) and flushes after a taken branch. It also keeps saturating stall/flush performance counters.

Parameters:
RST_CYCLES, 2, cycles the pipeline resets are held after RESET or halt exit (>=1)
FLUSH_CYCLES, 1, bubbles injected into reg_ifid_exmem after a taken branch (>=1)
CNT_W, 16, width of stall_cnt / flush_cnt
MXRB_MEM, 2'b01, S_MXRB encoding that selects data-memory read data for write-back

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
start  in  1  pulse: leave IDLE and begin execution
load_req  in  1  level: hold the core in LOAD so instruction memory can be written
halt_req  in  1  pulse: stop fetching and drain
id_RA  in  4  source A of the instruction in IF/ID
id_RB  in  4  source B of the instruction in IF/ID
id_use_RA  in  1  IF/ID instruction reads RA
id_use_RB  in  1  IF/ID instruction reads RB
ex_WC  in  4  destination of the instruction in EX/MEM
ex_W_RB  in  1  EX/MEM instruction writes the register bank
ex_S_MXRB  in  2  EX/MEM write-back source select
branch_taken  in  1  EX/MEM resolved a taken branch this cycle
pc_RESET  out  1  PC reset
pc_ENABLE  out  1  PC and IF/ID advance
reg_ifid_exmem_RESET  out  1  bubble/clear for the IF/ID->EX/MEM register
reg_ifid_exmem_ENABLE  out  1  load enable for the IF/ID->EX/MEM register
reg_exmem_wb_RESET  out  1  clear for the EX/MEM->WB register
reg_exmem_wb_ENABLE  out  1  load enable for the EX/MEM->WB register
im_load_en  out  1  permits im_WE (high only in LOAD)
running  out  1  high in RUN, STALL and FLUSH
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of flush bubbles

Behaviour:
- States: INIT, IDLE, LOAD, RUN, STALL, FLUSH, DRAIN. All outputs are decoded from the registered state, except the RUN hazard/branch decisions, which are combinational in the same cycle.
- RESET=1 (checked every edge, overrides everything, including mid-operation):
  - state <= INIT, rst_ctr <= RST_CYCLES-1, stall_cnt = flush_cnt = 0.
  - pc_RESET = both reg *_RESET = 1; all ENABLEs = 0; im_load_en = 0; running = 0.
- INIT:
  - All resets = 1, all enables = 0.
  - rst_ctr counts down; at 0 go to IDLE. INIT lasts exactly RST_CYCLES cycles after RESET deasserts.
- IDLE:
  - Resets = 0, enables = 0.
  - load_req -> LOAD; else start -> RUN. load_req has priority over start.
- LOAD:
  - im_load_en = 1; pc_RESET = 1; pipeline registers held in reset.
  - load_req deasserted -> INIT, so PC and pipeline are re-reset before the next run.
- RUN:
  - All enables = 1 and all resets = 0, unless one of the conditions below applies.
  - Hazard: ex_W_RB & (ex_S_MXRB==MXRB_MEM) & ((id_use_RA & id_RA==ex_WC) | (id_use_RB & id_RB==ex_WC)).
  - If hazard and not branch_taken:
    - pc_ENABLE = 0 (PC and IF/ID hold);
    - reg_ifid_exmem_RESET = 1 (bubble);
    - reg_exmem_wb_ENABLE = 1;
    - next state STALL; stall_cnt += 1.
  - If branch_taken (priority over hazard):
    - reg_ifid_exmem_RESET = 1 this cycle; PC enabled, so the branch target loads;
    - flush_cnt += 1;
    - if FLUSH_CYCLES > 1, go to FLUSH with fl_ctr = FLUSH_CYCLES-2.
  - halt_req (lowest priority, ignored if branch_taken or hazard that cycle): go to DRAIN, drn_ctr = 2.
- STALL:
  - Exactly one cycle, behaving as RUN with no hazard, then return to RUN.
  - Hazard is not re-evaluated in this cycle: the producer has advanced, so there is no double stall.
  - branch_taken is impossible here because EX holds a bubble; it is ignored.
- FLUSH:
  - reg_ifid_exmem_RESET = 1, PC enabled, flush_cnt += 1 per cycle.
  - Go to RUN when fl_ctr = 0, decrementing otherwise.
  - halt_req is ignored during FLUSH.
- DRAIN:
  - pc_ENABLE = 0; reg_ifid_exmem_RESET = 1; reg_exmem_wb_ENABLE = 1.
  - Lets in-flight instructions retire; after 2 cycles go to INIT.
- Counters: saturate at all-ones (no wrap). They are cleared only by RESET.
- running = 1 in RUN, STALL and FLUSH; 0 otherwise.
- Latency: a hazard is detected and a bubble inserted in the same cycle; zero added latency when there is no hazard.

Decomposition:
- Shared package pipe_pkg:
  - state enum;
  - MXRB_* encodings (MXRB_ALU, MXRB_MEM, MXRB_PC);
  - register-index width constant (4).
- One sub-module, hazard_detect: purely combinational. It takes the id_* and ex_* inputs and produces the hazard signal, so it can be reused by a later forwarding unit.
- The FSM and counters stay in pipeline_ctrl.

Test Plan:
1. Reset/INIT: assert RESET for 3 cycles, then release -> resets high exactly 2 cycles, then IDLE with all enables 0, counters 0.
2. Load gating: load_req=1 in IDLE -> im_load_en=1 and pc_RESET=1 while held; drop it -> INIT for 2 cycles, then IDLE; start -> RUN with running=1.
3. Load-use stall: ex_W_RB=1, ex_S_MXRB=01, ex_WC=5, id_RA=5, id_use_RA=1 -> that cycle pc_ENABLE=0 and reg_ifid_exmem_RESET=1; next cycle STALL, then RUN; stall_cnt=1. The same case with ex_S_MXRB=00 -> no stall.
4. Branch beats hazard: branch_taken=1 together with the hazard of scenario 3, FLUSH_CYCLES=2 -> pc_ENABLE=1, bubble for 2 cycles, flush_cnt=2, stall_cnt unchanged.
5. Halt/drain: halt_req in RUN -> 2 DRAIN cycles (pc_ENABLE=0, reg_exmem_wb_ENABLE=1), then INIT, then IDLE.
6. Mid-op reset and saturation: RESET asserted during STALL -> next cycle INIT and counters 0. With CNT_W=2, 5 stalls -> stall_cnt=3.
